// File: rtl/fp_div_shift_sub_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_div_shift_sub_if
// Description : Start/done handshake, operands, quotient and flags for the
//               sequential single-precision divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_div_shift_sub_if;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;

    modport master (
        output start, A, B,
        input  result, busy, done, overflow, underflow, div_by_zero
    );

    modport slave (
        input  start, A, B,
        output result, busy, done, overflow, underflow, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/fp_div_shift_sub.sv
`default_nettype none
// ============================================================================
// Module      : fp_div_shift_sub
// Description : IEEE-754 single-precision divider, restoring shift-subtract,
//               one quotient bit per cycle. FP_DIV_ROUND_NEAREST_EN selects
//               round-to-nearest-even; otherwise the quotient is truncated.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_div_shift_sub #(
    parameter logic [31:0] NAN_VALUE = 32'h7FC0_0000
) (
    input  wire logic          clk,
    input  wire logic          n_rst,
    fp_div_shift_sub_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_DIV  = 3'd2,
        S_NORM = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [4:0] c_LAST_ITER = 5'd25;

    state_t             r_state;
    logic [31:0]        r_a, r_b;
    logic [24:0]        r_rem;
    logic [23:0]        r_den;
    logic [25:0]        r_quo;
    logic signed [9:0]  r_exp;
    logic [4:0]         r_cnt;
    logic               r_sign;
    logic [31:0]        r_result;
    logic               r_busy, r_done, r_ovf, r_unf, r_dbz;

    // Operand classification; zero exponent (zero or subnormal) counts as zero
    logic [7:0]  w_ea, w_eb;
    logic [22:0] w_ma, w_mb;
    logic        w_sign, w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;

    assign w_ea     = r_a[30:23];
    assign w_eb     = r_b[30:23];
    assign w_ma     = r_a[22:0];
    assign w_mb     = r_b[22:0];
    assign w_sign   = r_a[31] ^ r_b[31];
    assign w_a_zero = (w_ea == 8'h00);
    assign w_b_zero = (w_eb == 8'h00);
    assign w_a_inf  = (w_ea == 8'hFF) && (w_ma == 23'd0);
    assign w_b_inf  = (w_eb == 8'hFF) && (w_mb == 23'd0);
    assign w_a_nan  = (w_ea == 8'hFF) && (w_ma != 23'd0);
    assign w_b_nan  = (w_eb == 8'hFF) && (w_mb != 23'd0);

    logic        w_special, w_spec_dbz;
    logic [31:0] w_spec_result;

    always_comb begin
        w_special     = 1'b1;
        w_spec_dbz    = 1'b0;
        w_spec_result = NAN_VALUE;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_result = NAN_VALUE;
        end else if (w_a_inf) begin
            w_spec_result = {w_sign, 8'hFF, 23'd0};
        end else if (w_b_inf) begin
            w_spec_result = {w_sign, 31'd0};
        end else if (w_b_zero) begin
            w_spec_result = {w_sign, 8'hFF, 23'd0};
            w_spec_dbz    = 1'b1;
        end else if (w_a_zero) begin
            w_spec_result = {w_sign, 31'd0};
        end else begin
            w_special     = 1'b0;
        end
    end

    // One restoring step
    logic        w_ge;
    logic [24:0] w_diff;

    assign w_ge   = (r_rem >= {1'b0, r_den});
    assign w_diff = w_ge ? (r_rem - {1'b0, r_den}) : r_rem;

    // Normalise, round, renormalise on mantissa carry-out
    logic [25:0]       w_q_n;
    logic signed [9:0] w_e_n, w_e_f;
    logic              w_guard, w_sticky, w_inc, w_carry;
    logic [24:0]       w_mant_rnd;
    logic [22:0]       w_mant_f;

    assign w_q_n    = r_quo[25] ? r_quo : {r_quo[24:0], 1'b0};
    assign w_e_n    = r_quo[25] ? r_exp : (r_exp - 10'sd1);
    assign w_guard  = w_q_n[1];
    assign w_sticky = w_q_n[0] | (|r_rem);

`ifdef FP_DIV_ROUND_NEAREST_EN
    assign w_inc = w_guard & (w_sticky | w_q_n[2]);
`else
    logic w_unused;
    assign w_inc    = 1'b0;
    assign w_unused = w_guard ^ w_sticky;
`endif

    assign w_mant_rnd = {1'b0, w_q_n[25:2]} + {24'd0, w_inc};
    assign w_carry    = w_mant_rnd[24];
    assign w_mant_f   = w_carry ? w_mant_rnd[23:1] : w_mant_rnd[22:0];
    assign w_e_f      = w_carry ? (w_e_n + 10'sd1) : w_e_n;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= S_IDLE;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_rem    <= 25'd0;
            r_den    <= 24'd0;
            r_quo    <= 26'd0;
            r_exp    <= 10'sd0;
            r_cnt    <= 5'd0;
            r_sign   <= 1'b0;
            r_result <= 32'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.A;
                        r_b     <= bus.B;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_special) begin
                        r_result <= w_spec_result;
                        r_ovf    <= 1'b0;
                        r_unf    <= 1'b0;
                        r_dbz    <= w_spec_dbz;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_sign  <= w_sign;
                        r_rem   <= {2'b01, w_ma};
                        r_den   <= {1'b1, w_mb};
                        r_exp   <= $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 10'sd127;
                        r_quo   <= 26'd0;
                        r_cnt   <= 5'd0;
                        r_state <= S_DIV;
                    end
                end
                S_DIV: begin
                    r_rem <= w_diff << 1;
                    r_quo <= {r_quo[24:0], w_ge};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == c_LAST_ITER) begin
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    r_ovf <= 1'b0;
                    r_unf <= 1'b0;
                    r_dbz <= 1'b0;
                    if (w_e_f >= 10'sd255) begin
                        r_ovf    <= 1'b1;
                        r_result <= {r_sign, 8'hFF, 23'd0};
                    end else if (w_e_f <= 10'sd0) begin
                        r_unf    <= 1'b1;
                        r_result <= {r_sign, 31'd0};
                    end else begin
                        r_result <= {r_sign, w_e_f[7:0], w_mant_f};
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.result      = r_result;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.overflow    = r_ovf;
    assign bus.underflow   = r_unf;
    assign bus.div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_fp_div_shift_sub.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_div_shift_sub
// Description : Scoreboard bench for fp_div_shift_sub with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_div_shift_sub;

    typedef struct {
        logic [31:0] res;
        logic [31:0] mask;
        logic [2:0]  flags;
        int          done_cyc;
        string       name;
    } exp_t;

    logic clk;
    logic n_rst;
    int   cyc;
    int   n_total;
    int   n_pass;
    int   n_issued;
    int   n_done;
    exp_t sb[$];

    fp_div_shift_sub_if bus();

    fp_div_shift_sub dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

`ifdef FP_DIV_ROUND_NEAREST_EN
    localparam logic [31:0] c_THIRD = 32'h3EAA_AAAB;
`else
    localparam logic [31:0] c_THIRD = 32'h3EAA_AAAA;
`endif

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, got, want);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(posedge clk) begin
        #1;
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, bus.result & e.mask, e.res & e.mask);
                check({e.name, "_flags"},
                      {29'd0, bus.overflow, bus.underflow, bus.div_by_zero},
                      {29'd0, e.flags});
                check({e.name, "_latency"}, cyc, e.done_cyc);
                n_done++;
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [31:0] mask,
                         input logic [2:0] flags, input int lat, input string name);
        exp_t e;
        @(negedge clk);
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        e.res = res; e.mask = mask; e.flags = flags;
        e.done_cyc = cyc + lat; e.name = name;
        sb.push_back(e);
        n_issued++;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 100; i++) begin
            if (n_done == n_issued) return;
            @(negedge clk);
        end
        n_total++;
        $display("FAIL %s_timeout: got %0d done pulses expected %0d", name, n_done, n_issued);
        sb.delete();
        n_done = n_issued;
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [2:0] flags,
                       input int lat, input string name);
        issue(a, b, res, 32'hFFFF_FFFF, flags, lat, name);
        wait_done(name);
    endtask

    initial begin
        cyc = 0; n_total = 0; n_pass = 0; n_issued = 0; n_done = 0;
        n_rst = 1'b0; bus.start = 1'b0; bus.A = 32'd0; bus.B = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_result", bus.result, 32'd0);
        check("reset_ctrl", {27'd0, bus.busy, bus.done, bus.overflow, bus.underflow, bus.div_by_zero}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;

        // Normal operands: flags {overflow, underflow, div_by_zero}
        run(32'h4110_0000, 32'h4040_0000, 32'h4040_0000, 3'b000, 29, "div_9_3");
        run(32'h3F80_0000, 32'h4040_0000, c_THIRD,       3'b000, 29, "div_1_3");
        run(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 29, "div_6_2");
        run(32'hC000_0000, 32'h3F00_0000, 32'hC080_0000, 3'b000, 29, "div_m2_half");
        run(32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 3'b100, 29, "overflow");
        run(32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 3'b010, 29, "underflow");
        issue(32'hC10C_0000, 32'h4086_B852, 32'h8000_0000, 32'h8000_0000, 3'b000, 29, "neg_sign");
        wait_done("neg_sign");

        // Special operands resolve in LOAD
        run(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 3'b001, 2, "div_by_zero");
        run(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b000, 2, "zero_zero");
        run(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b000, 2, "nan_in");
        run(32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 3'b000, 2, "inf_inf");
        run(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 3'b000, 2, "inf_x");
        run(32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 3'b000, 2, "x_inf");
        run(32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 3'b000, 2, "zero_x");
        run(32'h0000_0001, 32'hBF80_0000, 32'h8000_0000, 3'b000, 2, "subnormal_flush");

        // start while busy must be ignored
        issue(32'h4110_0000, 32'h4040_0000, 32'h4040_0000, 32'hFFFF_FFFF, 3'b000, 29, "busy_restart");
        repeat (3) @(negedge clk);
        bus.A = 32'h3F80_0000; bus.B = 32'h4040_0000; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("busy_restart");

        // Reset mid-division: outputs clear at once, no done pulse follows
        @(negedge clk);
        bus.A = 32'h4110_0000; bus.B = 32'h4040_0000; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        n_rst = 1'b0;
        #1;
        check("midrst_result", bus.result, 32'd0);
        check("midrst_ctrl", {27'd0, bus.busy, bus.done, bus.overflow, bus.underflow, bus.div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (40) @(negedge clk);
        run(32'h4110_0000, 32'h4040_0000, 32'h4040_0000, 3'b000, 29, "after_reset");

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_div_shift_sub.md
Name: fp_div_shift_sub

Overview:
- Sequential IEEE-754 single-precision divider using iterative restoring shift-subtract.
- Inverse operation of the shift-add multiplier; sits beside it in the FP arithmetic unit and shares its operand/flag conventions.
- Computes A / B with a start/done handshake. Flags overflow, underflow and divide-by-zero.

Parameters:
- NAN_VALUE, 32'h7FC0_0000: canonical quiet NaN returned for invalid operations.

Ports:
- clk  input  1  rising-edge clock
- n_rst  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- A  input  32  dividend (IEEE-754 single)
- B  input  32  divisor (IEEE-754 single)
- result  output  32  quotient; held stable between done pulses
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; result and flags are valid in that cycle
- overflow  output  1  quotient exponent too large; result = ±inf
- underflow  output  1  quotient exponent too small; result = ±0
- div_by_zero  output  1  finite nonzero A divided by zero

Behaviour:
- Reset (n_rst=0, asynchronous) forces: state IDLE; result=0, busy=0, done=0, all flags=0.
- Reset mid-operation aborts the division. No done pulse is produced for the aborted operation.
- start while busy=1 is ignored. A and B are latched on the accepting edge, so later input changes have no effect.
- Unpack: sign = sA^sB. Zero-exponent inputs (zero or subnormal) are flushed to ±0 before classification.
- Special cases, priority order, each resolved in LOAD:
  - any NaN, 0/0 or inf/inf -> NAN_VALUE
  - inf/x -> ±inf
  - x/inf -> ±0
  - x/0 -> ±inf with div_by_zero=1
  - 0/x -> ±0
- FSM:
  - IDLE --start--> LOAD.
  - LOAD: special operand -> DONE; otherwise -> DIV with R={1,Ma} (25b), D={1,Mb}, E=Ea-Eb+127 (10b signed), cnt=0.
  - DIV: 26 iterations, one per cycle. Each cycle: if R>=D then R=R-D and q_bit=1, else q_bit=0; Q={Q,q_bit}; R=R<<1. After cnt=25 -> NORM.
  - NORM: if Q[25]=0 then Q<<=1 and E-=1. Guard=Q[1]; sticky=Q[0]|(R!=0). Round per the Optional Feature. A mantissa carry-out renormalizes and does E+=1. Then range check:
    - E>=255: overflow=1, result={sign,8'hFF,23'h0}
    - E<=0: underflow=1, result={sign,31'h0}
    - otherwise result={sign,E[7:0],Q[24:2]}
  - NORM -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Latency from the edge that samples start to the done-high cycle:
  - normal operands: 29 edges
  - special operands: 2 edges
- Flags are updated only on entering DONE; each operation clears all flags before setting its own.
- busy deasserts in the DONE cycle, so start is acceptable in the cycle after done. Back-to-back operations are supported.

Optional Feature:
- Macro FP_DIV_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even. Increment when guard & (sticky | Q[2]).
- Undefined: truncation (round toward zero); guard and sticky are ignored.
- Handshake, latency and special-case results are identical in both builds.

Test Plan:
- 9.0/3.0: A=41100000, B=40400000, pulse start -> done after 29 edges, result=40400000, all flags 0.
- 1.0/3.0: A=3F800000, B=40400000 -> result=3EAAAAAB with FP_DIV_ROUND_NEAREST_EN defined, 3EAAAAAA without.
- Divide by zero: A=3F800000, B=00000000 -> result=7F800000, div_by_zero=1, done after 2 edges. Invalid case: A=0, B=0 -> result=7FC00000.
- Range limits:
  - A=7F000000, B=00800000 -> result=7F800000, overflow=1.
  - A=00800000, B=7F000000 -> result=00000000, underflow=1.
  - A=C10C0000, B=4086B852 -> sign bit of result=1.
- Reset mid-operation and busy start:
  - Start 41100000/40400000, drop n_rst at iteration 10 -> outputs go to 0 immediately, no done pulse.
  - After reset release, a fresh start completes normally.
  - start re-pulsed while busy=1 is ignored; the original result is delivered.
